// File: rtl/ps2_scan_decoder_pkg.sv
// Shared constants, state encoding and helpers for the PS/2 Set-2 scan decoder.
package ps2_defs;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EXT     = 3'd1;
  localparam logic [2:0] S_BRK     = 3'd2;
  localparam logic [2:0] S_EXT_BRK = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    EXT     = S_EXT,
    BRK     = S_BRK,
    EXT_BRK = S_EXT_BRK,
    PAUSE   = S_PAUSE
  } state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [7:0] LOCK_CODE_CAPS   = 8'h58;
  localparam logic [7:0] LOCK_CODE_NUM    = 8'h77;
  localparam logic [7:0] LOCK_CODE_SCROLL = 8'h7E;

  localparam int unsigned LOCK_W      = 3;
  localparam int unsigned LOCK_CAPS   = 2;
  localparam int unsigned LOCK_NUM    = 1;
  localparam int unsigned LOCK_SCROLL = 0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_evt_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
  endfunction

  // One-hot lock bit selected by a (non-extended) scan code, zero if none.
  function automatic logic [LOCK_W-1:0] lock_hit(input logic [7:0] code);
    logic [LOCK_W-1:0] h;
    h              = '0;
    h[LOCK_CAPS]   = (code == LOCK_CODE_CAPS);
    h[LOCK_NUM]    = (code == LOCK_CODE_NUM);
    h[LOCK_SCROLL] = (code == LOCK_CODE_SCROLL);
    return h;
  endfunction

endpackage

// File: rtl/ps2_strobe_sync.sv
// Registers the simulator byte strobe twice and emits a registered one-cycle
// byte strobe on its rising edge, together with the byte captured alongside it.
module ps2_strobe_sync (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_act,
  input  logic [7:0] i_code,
  output logic       o_byte_stb,
  output logic [7:0] o_byte_q
);

  logic       r_act_q1;
  logic       r_act_q2;
  logic [7:0] r_code_q1;
  logic       r_stb;
  logic [7:0] r_byte;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act_q1  <= 1'b0;
      r_act_q2  <= 1'b0;
      r_code_q1 <= 8'h00;
      r_stb     <= 1'b0;
      r_byte    <= 8'h00;
    end else begin
      r_act_q1  <= i_act;
      r_code_q1 <= i_code;
      r_act_q2  <= r_act_q1;
      r_stb     <= r_act_q1 & ~r_act_q2;
      r_byte    <= r_code_q1;
    end
  end

  assign o_byte_stb = r_stb;
  assign o_byte_q   = r_byte;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 decoder: make/break/E0/E1 sequences to key events plus lock state.
// Build option PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the last key.
module ps2_scan_decoder
  import ps2_defs::*;
#(
  parameter int unsigned PAUSE_LEN      = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        key_action,
  input  logic [7:0]  scan_code,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_extended,
  output logic        key_released,
  output logic        key_pause,
  output logic [2:0]  ps2_lock_control,
  output logic        seq_error
);

  localparam int unsigned SKIP_W = $clog2(PAUSE_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic              w_byte_stb;
  logic [7:0]        w_byte_q;

  state_t            r_state, w_state_n;
  logic [SKIP_W-1:0] r_skip, w_skip_n;
  logic [TMO_W-1:0]  r_tmo, w_tmo_n;
  logic [LOCK_W-1:0] r_held, w_held_n;
  logic [LOCK_W-1:0] r_lock, w_lock_n;
  logic              r_valid, w_valid_n;
  key_evt_t          r_evt, w_evt_n;
  logic              r_pause, w_pause_n;
  logic              r_err, w_err_n;

  logic              w_emit;
  logic              w_emit_ext;
  logic              w_emit_rel;
  logic              w_suppress;
  logic [LOCK_W-1:0] w_hit;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic              r_last_vld, w_last_vld_n;
  logic              r_last_ext, w_last_ext_n;
  logic [7:0]        r_last_code, w_last_code_n;
`endif

  ps2_strobe_sync u_sync (
    .i_clk      (CLOCK_50),
    .i_rst      (reset),
    .i_act      (key_action),
    .i_code     (scan_code),
    .o_byte_stb (w_byte_stb),
    .o_byte_q   (w_byte_q)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_skip  <= '0;
      r_tmo   <= '0;
      r_held  <= '0;
      r_lock  <= '0;
      r_valid <= 1'b0;
      r_evt   <= '0;
      r_pause <= 1'b0;
      r_err   <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      r_last_vld  <= 1'b0;
      r_last_ext  <= 1'b0;
      r_last_code <= 8'h00;
`endif
    end else begin
      r_state <= w_state_n;
      r_skip  <= w_skip_n;
      r_tmo   <= w_tmo_n;
      r_held  <= w_held_n;
      r_lock  <= w_lock_n;
      r_valid <= w_valid_n;
      r_evt   <= w_evt_n;
      r_pause <= w_pause_n;
      r_err   <= w_err_n;
`ifdef PS2_TYPEMATIC_FILTER_EN
      r_last_vld  <= w_last_vld_n;
      r_last_ext  <= w_last_ext_n;
      r_last_code <= w_last_code_n;
`endif
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_skip_n   = r_skip;
    w_tmo_n    = r_tmo;
    w_held_n   = r_held;
    w_lock_n   = r_lock;
    w_valid_n  = 1'b0;
    w_evt_n    = r_evt;
    w_pause_n  = 1'b0;
    w_err_n    = 1'b0;
    w_emit     = 1'b0;
    w_emit_ext = 1'b0;
    w_emit_rel = 1'b0;
    w_suppress = 1'b0;
    w_hit      = '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    w_last_vld_n  = r_last_vld;
    w_last_ext_n  = r_last_ext;
    w_last_code_n = r_last_code;
`endif

    if (w_byte_stb) begin
      w_tmo_n = '0;
      case (r_state)
        IDLE: begin
          if (w_byte_q == PS2_EXT) begin
            w_state_n = EXT;
          end else if (w_byte_q == PS2_BRK) begin
            w_state_n = BRK;
          end else if (w_byte_q == PS2_PAUSE) begin
            w_state_n = PAUSE;
            w_skip_n  = SKIP_W'(PAUSE_LEN);
          end else begin
            w_emit = 1'b1;
          end
        end
        EXT: begin
          if (w_byte_q == PS2_BRK) begin
            w_state_n = EXT_BRK;
          end else begin
            w_state_n  = IDLE;
            w_err_n    = is_prefix(w_byte_q);
            w_emit     = ~is_prefix(w_byte_q);
            w_emit_ext = 1'b1;
          end
        end
        BRK: begin
          w_state_n  = IDLE;
          w_err_n    = is_prefix(w_byte_q);
          w_emit     = ~is_prefix(w_byte_q);
          w_emit_rel = 1'b1;
        end
        EXT_BRK: begin
          w_state_n  = IDLE;
          w_err_n    = is_prefix(w_byte_q);
          w_emit     = ~is_prefix(w_byte_q);
          w_emit_ext = 1'b1;
          w_emit_rel = 1'b1;
        end
        PAUSE: begin
          // Pause bytes are swallowed whole, including the embedded 77.
          if (r_skip <= SKIP_W'(1)) begin
            w_skip_n  = '0;
            w_pause_n = 1'b1;
            w_state_n = IDLE;
          end else begin
            w_skip_n = SKIP_W'(r_skip - SKIP_W'(1));
          end
        end
        default: w_state_n = IDLE;
      endcase
    end else if (r_state != IDLE) begin
      if (r_tmo >= TMO_LAST) begin
        w_err_n   = 1'b1;
        w_state_n = IDLE;
      end else begin
        w_tmo_n = TMO_W'(r_tmo + TMO_W'(1));
      end
    end else begin
      w_tmo_n = '0;
    end

    if (w_emit) begin
      // Held flags stop typematic repeats from re-toggling a lock bit.
      w_hit = w_emit_ext ? '0 : lock_hit(w_byte_q);
      if (w_emit_rel) begin
        w_held_n = r_held & ~w_hit;
      end else begin
        w_lock_n = r_lock ^ (w_hit & ~r_held);
        w_held_n = r_held | w_hit;
      end
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (w_emit_rel) begin
        w_last_vld_n = 1'b0;
      end else begin
        w_suppress    = r_last_vld && (r_last_ext == w_emit_ext) && (r_last_code == w_byte_q);
        w_last_vld_n  = 1'b1;
        w_last_ext_n  = w_emit_ext;
        w_last_code_n = w_byte_q;
      end
`endif
      if (!w_suppress) begin
        w_valid_n    = 1'b1;
        w_evt_n.code = w_byte_q;
        w_evt_n.ext  = w_emit_ext;
        w_evt_n.rel  = w_emit_rel;
      end
    end
  end

  assign key_valid        = r_valid;
  assign key_code         = r_evt.code;
  assign key_extended     = r_evt.ext;
  assign key_released     = r_evt.rel;
  assign key_pause        = r_pause;
  assign ps2_lock_control = r_lock;
  assign seq_error        = r_err;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: directed byte sequences push expected
// events; a negedge monitor pops and checks each event the decoder reports.
module tb_ps2_scan_decoder;

  localparam int unsigned TMO = 40;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  localparam int K_KEY   = 0;
  localparam int K_PAUSE = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [2:0] lock;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       act;
  logic [7:0] code_in;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       key_pause;
  logic [2:0] lock;
  logic       seq_error;

  exp_t       exp_q[$];
  exp_t       e;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         t_send = 0;
  int         kind;
  bit         ok;
  logic [7:0] m_code = 8'h00;
  logic       m_ext = 1'b0;
  logic       m_rel = 1'b0;

  ps2_scan_decoder #(.PAUSE_LEN(7), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50         (clk),
    .reset            (rst),
    .key_action       (act),
    .scan_code        (code_in),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .key_extended     (key_extended),
    .key_released     (key_released),
    .key_pause        (key_pause),
    .ps2_lock_control (lock),
    .seq_error        (seq_error)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every reported event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (key_valid || key_pause || seq_error)) begin
      kind = key_valid ? K_KEY : (key_pause ? K_PAUSE : K_ERR);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event kind=%0d code=%h ext=%b rel=%b lock=%b cyc=%0d",
                 kind, key_code, key_extended, key_released, lock, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == K_KEY) begin
          m_code = e.code;
          m_ext  = e.ext;
          m_rel  = e.rel;
        end
        ok = (kind == e.kind) && ($countones({key_valid, key_pause, seq_error}) == 1) &&
             (key_code == m_code) && (key_extended == m_ext) && (key_released == m_rel) &&
             (lock == e.lock) && ((e.cyc < 0) || (cyc == e.cyc));
        if (!ok) begin
          bad++;
          $display("FAIL event got kind=%0d code=%h ext=%b rel=%b lock=%b cyc=%0d want kind=%0d code=%h ext=%b rel=%b lock=%b cyc=%0d",
                   kind, key_code, key_extended, key_released, lock, cyc,
                   e.kind, m_code, m_ext, m_rel, e.lock, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_in = b;
    act     = 1'b1;
    t_send  = cyc;
    @(negedge clk);
    act = 1'b0;
  endtask

  task automatic expect_ev(input int k, input logic [7:0] c, input logic x, input logic r,
                           input logic [2:0] l, input bit timed);
    exp_t ne;
    ne.kind = k;
    ne.code = c;
    ne.ext  = x;
    ne.rel  = r;
    ne.lock = l;
    ne.cyc  = timed ? t_send + 3 : -1;
    exp_q.push_back(ne);
  endtask

  task automatic key(input logic [7:0] c, input logic x, input logic r, input logic [2:0] l);
    expect_ev(K_KEY, c, x, r, l, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (lock !== 3'b000) begin
      bad++;
      $display("FAIL %s_lock got %b want 000", name, lock);
    end
    total++;
    if (key_code !== 8'h00) begin
      bad++;
      $display("FAIL %s_code got %h want 00", name, key_code);
    end
    total++;
    if ({key_valid, key_extended, key_released, key_pause, seq_error} !== 5'b0) begin
      bad++;
      $display("FAIL %s_flags got %b want 00000", name,
               {key_valid, key_extended, key_released, key_pause, seq_error});
    end
  endtask

  initial begin
    rst     = 1'b1;
    act     = 1'b0;
    code_in = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain make / break.
    send(8'h1C);                    key(8'h1C, 0, 0, 3'b000);
    send(8'hF0); send(8'h1C);       key(8'h1C, 0, 1, 3'b000);
    // Extended make / break.
    send(8'hE0); send(8'h75);       key(8'h75, 1, 0, 3'b000);
    send(8'hE0); send(8'hF0); send(8'h75); key(8'h75, 1, 1, 3'b000);
    drain();

    // Caps lock with typematic repeats.
    send(8'h58);                    key(8'h58, 0, 0, 3'b100);
    send(8'h58); if (!FILT)         key(8'h58, 0, 0, 3'b100);
    send(8'h58); if (!FILT)         key(8'h58, 0, 0, 3'b100);
    send(8'hF0); send(8'h58);       key(8'h58, 0, 1, 3'b100);
    send(8'h58);                    key(8'h58, 0, 0, 3'b000);
    send(8'hF0); send(8'h58);       key(8'h58, 0, 1, 3'b000);
    // Num lock, then extended 77 has no lock effect.
    send(8'h77);                    key(8'h77, 0, 0, 3'b010);
    send(8'hF0); send(8'h77);       key(8'h77, 0, 1, 3'b010);
    send(8'hE0); send(8'h77);       key(8'h77, 1, 0, 3'b010);
    send(8'hE0); send(8'hF0); send(8'h77); key(8'h77, 1, 1, 3'b010);
    drain();

    // Pause sequence: one pulse, no key events, lock untouched.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_ev(K_PAUSE, 8'h00, 0, 0, 3'b010, 1'b1);
    send(8'h7E);                    key(8'h7E, 0, 0, 3'b011);
    send(8'hF0); send(8'h7E);       key(8'h7E, 0, 1, 3'b011);
    drain();

    // Timeout of a dangling E0, then normal decode from IDLE.
    send(8'hE0);
    expect_ev(K_ERR, 8'h00, 0, 0, 3'b011, 1'b0);
    drain();
    send(8'h1C);                    key(8'h1C, 0, 0, 3'b011);
    // Illegal prefixes in BRK, EXT and EXT_BRK.
    send(8'hF0); send(8'hF0);       expect_ev(K_ERR, 8'h00, 0, 0, 3'b011, 1'b1);
    send(8'hE0); send(8'hE1);       expect_ev(K_ERR, 8'h00, 0, 0, 3'b011, 1'b1);
    send(8'hE0); send(8'hF0); send(8'hF0); expect_ev(K_ERR, 8'h00, 0, 0, 3'b011, 1'b1);
    send(8'h2B);                    key(8'h2B, 0, 0, 3'b011);
    drain();

    // Repeated non-lock makes (filtered only when the feature is built in).
    send(8'h1C);                    key(8'h1C, 0, 0, 3'b011);
    send(8'h1C); if (!FILT)         key(8'h1C, 0, 0, 3'b011);
    send(8'h1C); if (!FILT)         key(8'h1C, 0, 0, 3'b011);
    send(8'hF0); send(8'h1C);       key(8'h1C, 0, 1, 3'b011);
    drain();

    // Async reset mid-sequence with caps set.
    send(8'h58);                    key(8'h58, 0, 0, 3'b111);
    send(8'hF0); send(8'h58);       key(8'h58, 0, 1, 3'b111);
    drain();
    send(8'hE0);
    #3 rst = 1'b1;
    #1 check_zero("async_reset");
    m_code = 8'h00;
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h75);                    key(8'h75, 0, 0, 3'b000);
    send(8'h58);                    key(8'h58, 0, 0, 3'b100);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
